tlb_refill: RTL and testbench

- Hardware page-table walker that services TLB misses.
- On a miss it latches the faulting virtual page and reads one PTE from a single-level page table at ptbr_i + vpn*4 over a request/grant/rvalid memory port.
- A valid PTE is written into the TLB through its write interface (virtual page, physical page, write enable). An invalid PTE raises a page fault.
- Sits between the TLB miss output and the data-memory arbiter.

---
 rtl/tlb_refill_pkg.sv | 24 ++
 rtl/tlb_refill.sv | 198 +++++++++++++++++++
 tb/tb_tlb_refill.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_refill_pkg.sv
// Shared definitions for the TLB refill page-table walker: default geometry,
// PTE field positions, walker state encoding and the PTE address helper.
package tlb_refill_pkg;

    localparam int OFFSET_DEF         = 12;
    localparam int PHYS_ADDR_SIZE_DEF = 20;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int PTE_VALID_BIT      = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    // Byte address of a 4-byte PTE; the sum wraps modulo 2^32.
    function automatic logic [31:0] pte_addr(input logic [31:0] base, input logic [31:0] vpn_word);
        return base + (vpn_word << 2);
    endfunction

endpackage

// File: rtl/tlb_refill.sv
// Single-level hardware page-table walker servicing TLB misses.
// Optional watchdog (timeout_o) enabled by defining TLB_REFILL_TIMEOUT_EN.
module tlb_refill
    import tlb_refill_pkg::*;
#(
    parameter int OFFSET         = OFFSET_DEF,
    parameter int PHYS_ADDR_SIZE = PHYS_ADDR_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                miss_i,
    input  logic [31:0]         miss_vaddr_i,
    input  logic [31:0]         ptbr_i,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic [31-OFFSET:0]  w_virtual_page_o,
    output logic [31-OFFSET:0]  w_phys_page_o,
    output logic                write_enable_o,
    output logic                busy_o,
    output logic                fault_o,
`ifdef TLB_REFILL_TIMEOUT_EN
    output logic                timeout_o,
`endif
    output logic [31:0]         fault_vaddr_o
);

    localparam int VPN_W = 32 - OFFSET;
    localparam int PPN_W = PHYS_ADDR_SIZE - OFFSET;

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        vaddr_r;
    logic               tmo_s;
    logic               tmo_fault_s;
    logic               drain_pend_s;

    logic               mem_req_r;
    logic [31:0]        mem_addr_r;
    logic [VPN_W-1:0]   w_vp_r;
    logic [VPN_W-1:0]   w_pp_r;
    logic               we_r;
    logic               busy_r;
    logic               fault_r;
    logic [31:0]        fault_vaddr_r;
    logic               unused_s;

    // Next-state decode; flush during an accepted request must still drain the response.
    always_comb begin
        state_s     = state_r;
        tmo_fault_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (miss_i && !flush_i) state_s = ST_REQ;
                else                    state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    if (flush_i) state_s = ST_DRAIN;
                    else         state_s = ST_WAIT;
                end else if (flush_i) begin
                    state_s = ST_IDLE;
                end else if (tmo_s) begin
                    state_s     = ST_FAULT;
                    tmo_fault_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (flush_i)                        state_s = ST_IDLE;
                    else if (mem_rdata_i[PTE_VALID_BIT]) state_s = ST_WRITE;
                    else                                state_s = ST_FAULT;
                end else if (flush_i) begin
                    state_s = ST_DRAIN;
                end else if (tmo_s) begin
                    state_s     = ST_FAULT;
                    tmo_fault_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid_i) state_s = ST_IDLE;
                else              state_s = ST_DRAIN;
            end
            ST_WRITE: state_s = ST_IDLE;
            ST_FAULT: begin
                if (drain_pend_s) state_s = ST_DRAIN;
                else              state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Latch the missing address when a walk starts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                                   vaddr_r <= 32'h0;
        else if (state_r == ST_IDLE && state_s == ST_REQ) vaddr_r <= miss_vaddr_i;
        else                                            vaddr_r <= vaddr_r;
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_req_r     <= 1'b0;
            mem_addr_r    <= 32'h0;
            w_vp_r        <= {VPN_W{1'b0}};
            w_pp_r        <= {VPN_W{1'b0}};
            we_r          <= 1'b0;
            busy_r        <= 1'b0;
            fault_r       <= 1'b0;
            fault_vaddr_r <= 32'h0;
        end else begin
            mem_req_r <= (state_s == ST_REQ);
            busy_r    <= (state_s != ST_IDLE);
            we_r      <= (state_s == ST_WRITE);
            fault_r   <= (state_s == ST_FAULT);
            if (state_r == ST_IDLE && state_s == ST_REQ)
                mem_addr_r <= pte_addr(ptbr_i, {{OFFSET{1'b0}}, miss_vaddr_i[31:OFFSET]});
            else if (state_s != ST_REQ)
                mem_addr_r <= 32'h0;
            else
                mem_addr_r <= mem_addr_r;
            if (state_s == ST_WRITE) begin
                w_vp_r <= vaddr_r[31:OFFSET];
                w_pp_r <= {{(VPN_W-PPN_W){1'b0}}, mem_rdata_i[PHYS_ADDR_SIZE-1:OFFSET]};
            end else begin
                w_vp_r <= {VPN_W{1'b0}};
                w_pp_r <= {VPN_W{1'b0}};
            end
            if (state_s == ST_FAULT) fault_vaddr_r <= vaddr_r;
            else                     fault_vaddr_r <= fault_vaddr_r;
        end
    end

`ifdef TLB_REFILL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_r;
    logic             drain_pend_r;
    logic             timeout_r;

    assign tmo_s        = ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                          (cnt_r == CNT_W'(TIMEOUT_CYCLES));
    assign drain_pend_s = drain_pend_r;

    // Watchdog: cleared on entry to REQ, counts while a request or response is outstanding.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r        <= {CNT_W{1'b0}};
            drain_pend_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            if (state_r != ST_REQ && state_s == ST_REQ)
                cnt_r <= {CNT_W{1'b0}};
            else if (state_r == ST_REQ || state_r == ST_WAIT)
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else
                cnt_r <= cnt_r;
            // A granted request still owes a response after a WAIT timeout.
            if (tmo_fault_s && state_r == ST_WAIT) drain_pend_r <= 1'b1;
            else if (state_r == ST_FAULT)          drain_pend_r <= 1'b0;
            else                                   drain_pend_r <= drain_pend_r;
            timeout_r <= tmo_fault_s;
        end
    end

    assign timeout_o = timeout_r;
`else
    assign tmo_s        = 1'b0;
    assign drain_pend_s = 1'b0;
`endif

    assign unused_s = ^{mem_rdata_i[31:PHYS_ADDR_SIZE], mem_rdata_i[OFFSET-1:1], tmo_fault_s,
                        (TIMEOUT_CYCLES > 0)};

    assign mem_req_o        = mem_req_r;
    assign mem_addr_o       = mem_addr_r;
    assign w_virtual_page_o = w_vp_r;
    assign w_phys_page_o    = w_pp_r;
    assign write_enable_o   = we_r;
    assign busy_o           = busy_r;
    assign fault_o          = fault_r;
    assign fault_vaddr_o    = fault_vaddr_r;

endmodule

// File: tb/tb_tlb_refill.sv
// Directed self-checking bench for tlb_refill; exercises the watchdog too when
// TLB_REFILL_TIMEOUT_EN is defined.
module tb_tlb_refill;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        miss_i;
    logic [31:0] miss_vaddr_i;
    logic [31:0] ptbr_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [19:0] w_virtual_page_o;
    logic [19:0] w_phys_page_o;
    logic        write_enable_o;
    logic        busy_o;
    logic        fault_o;
    logic [31:0] fault_vaddr_o;
`ifdef TLB_REFILL_TIMEOUT_EN
    logic        timeout_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    tlb_refill dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .miss_i(miss_i), .miss_vaddr_i(miss_vaddr_i),
        .ptbr_i(ptbr_i), .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .w_virtual_page_o(w_virtual_page_o), .w_phys_page_o(w_phys_page_o),
        .write_enable_o(write_enable_o), .busy_o(busy_o), .fault_o(fault_o),
`ifdef TLB_REFILL_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .fault_vaddr_o(fault_vaddr_o)
    );

    // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] va);
        miss_i = 1'b1; miss_vaddr_i = va;
        tick();
        miss_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; miss_i = 1'b0; miss_vaddr_i = 32'h0; ptbr_i = 32'h0; flush_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        tick(); tick();
        n_vec++;
        if ({mem_req_o, write_enable_o, busy_o, fault_o} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {mem_req_o, write_enable_o, busy_o, fault_o});
        end
        n_vec++;
        if ({mem_addr_o, w_virtual_page_o, w_phys_page_o, fault_vaddr_o} !== 104'h0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", {mem_addr_o, w_virtual_page_o, w_phys_page_o, fault_vaddr_o});
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_write();
        ptbr_i = 32'h0001_0000;
        start_miss(32'h0040_3ABC);
        n_vec++;
        if ({mem_req_o, busy_o} !== 2'b11) begin
            n_err++; $display("FAIL wr_req: got %b expected 11", {mem_req_o, busy_o});
        end
        n_vec++;
        if (mem_addr_o !== 32'h0001_100C) begin
            n_err++; $display("FAIL wr_addr: got %h expected 0001100c", mem_addr_o);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0008_7001;
        n_vec++;
        if ({mem_req_o, write_enable_o, busy_o} !== 3'b001) begin
            n_err++; $display("FAIL wr_wait: got %b expected 001", {mem_req_o, write_enable_o, busy_o});
        end
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        n_vec++;
        if ({write_enable_o, w_virtual_page_o, w_phys_page_o} !== {1'b1, 20'h00403, 20'h00087}) begin
            n_err++; $display("FAIL wr_strobe: got we=%b vp=%h pp=%h expected we=1 vp=00403 pp=00087",
                              write_enable_o, w_virtual_page_o, w_phys_page_o);
        end
        tick();
        n_vec++;
        if ({write_enable_o, busy_o, fault_o} !== 3'b000) begin
            n_err++; $display("FAIL wr_done: got %b expected 000", {write_enable_o, busy_o, fault_o});
        end
    endtask

    task automatic test_fault();
        logic saw_we = 1'b0;
        start_miss(32'h0040_3ABC);
        saw_we |= write_enable_o;
        mem_gnt_i = 1'b1;
        tick();
        saw_we |= write_enable_o;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0008_7000;
        tick();
        saw_we |= write_enable_o;
        mem_rvalid_i = 1'b0;
        n_vec++;
        if ({fault_o, fault_vaddr_o} !== {1'b1, 32'h0040_3ABC}) begin
            n_err++; $display("FAIL flt_pulse: got fault=%b va=%h expected fault=1 va=00403abc", fault_o, fault_vaddr_o);
        end
        tick();
        saw_we |= write_enable_o;
        n_vec++;
        if ({fault_o, busy_o, fault_vaddr_o} !== {2'b00, 32'h0040_3ABC}) begin
            n_err++; $display("FAIL flt_after: got fault=%b busy=%b va=%h expected 0 0 00403abc", fault_o, busy_o, fault_vaddr_o);
        end
        n_vec++;
        if (saw_we !== 1'b0) begin
            n_err++; $display("FAIL flt_no_write: got %b expected 0", saw_we);
        end
    endtask

    task automatic test_grant_stall();
        int bad = 0;
        start_miss(32'h0040_3ABC);
        miss_i = 1'b1; miss_vaddr_i = 32'h1234_5000;
        for (int i = 0; i < 6; i++) begin
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0001_100C) bad++;
            if (i < 5) tick();
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        miss_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0005_5001;
        tick();
        mem_rvalid_i = 1'b0;
        n_vec++;
        if ({write_enable_o, w_virtual_page_o, w_phys_page_o} !== {1'b1, 20'h00403, 20'h00055}) begin
            n_err++; $display("FAIL stall_write: got we=%b vp=%h pp=%h expected we=1 vp=00403 pp=00055",
                              write_enable_o, w_virtual_page_o, w_phys_page_o);
        end
        tick();
    endtask

    task automatic test_flush_drain();
        int bad = 0;
        start_miss(32'h0040_3ABC);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (busy_o !== 1'b1 || mem_req_o !== 1'b0 || write_enable_o !== 1'b0 || fault_o !== 1'b0) bad++;
            if (i < 2) tick();
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++; $display("FAIL drain_hold: got %0d bad cycles expected 0", bad);
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0008_7001;
        tick();
        mem_rvalid_i = 1'b0;
        n_vec++;
        if ({busy_o, write_enable_o, fault_o} !== 3'b000) begin
            n_err++; $display("FAIL drain_exit: got %b expected 000", {busy_o, write_enable_o, fault_o});
        end
    endtask

    task automatic test_wrap_flush_req();
        ptbr_i = 32'hFFFF_FFF0;
        start_miss(32'h0000_8123);
        n_vec++;
        if (mem_addr_o !== 32'h0000_0010) begin
            n_err++; $display("FAIL wrap_addr: got %h expected 00000010", mem_addr_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_vec++;
        if ({mem_req_o, busy_o} !== 2'b00) begin
            n_err++; $display("FAIL req_flush: got %b expected 00", {mem_req_o, busy_o});
        end
        ptbr_i = 32'h0001_0000;
    endtask

    task automatic test_reset_mid_wait();
        start_miss(32'h0040_3ABC);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        n_vec++;
        if ({mem_req_o, busy_o, fault_o, write_enable_o, fault_vaddr_o} !== 36'h0) begin
            n_err++; $display("FAIL rst_async: got %h expected 0", {mem_req_o, busy_o, fault_o, write_enable_o, fault_vaddr_o});
        end
        rst_n_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0008_7001;
        tick();
        mem_rvalid_i = 1'b0;
        n_vec++;
        if ({write_enable_o, busy_o, fault_o} !== 3'b000) begin
            n_err++; $display("FAIL rst_late_rvalid: got %b expected 000", {write_enable_o, busy_o, fault_o});
        end
    endtask

`ifdef TLB_REFILL_TIMEOUT_EN
    task automatic test_timeout();
        int waited = 0;
        start_miss(32'h0040_3ABC);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        while (fault_o !== 1'b1 && waited < 400) begin
            tick(); waited++;
        end
        n_vec++;
        if ({fault_o, timeout_o} !== 2'b11) begin
            n_err++; $display("FAIL tmo_pulse: got %b after %0d cycles expected 11", {fault_o, timeout_o}, waited);
        end
        tick();
        n_vec++;
        if ({busy_o, fault_o, timeout_o} !== 3'b100) begin
            n_err++; $display("FAIL tmo_drain: got %b expected 100", {busy_o, fault_o, timeout_o});
        end
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL tmo_idle: got %b expected 0", busy_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_fault();
        test_grant_stall();
        test_flush_drain();
        test_wrap_flush_req();
        test_reset_mid_wait();
`ifdef TLB_REFILL_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
